obj_layer_addr: RTL and testbench

- Multi-object sprite/terrain ROM address generator for the VGA path. Successor to the single-object terrain address block.
- Handles NUM_OBJ independent rectangular objects, each with:
  - screen pivot and size
  - source-memory pivot
  - enable and horizontal-flip controls
- Object parameters are double-buffered: written at any time, committed once per frame.
- Output is a registered, 2-stage pipelined address, enable and winning object index. Lowest object index has highest priority.

---
 rtl/obj_layer_addr.sv | 191 +++++++++++++++++++
 tb/tb_obj_layer_addr.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_layer_addr.sv
// obj_layer_addr
//   Multi-object sprite/terrain ROM address generator for the VGA path.
//   NUM_OBJ rectangular objects, each with a screen pivot/size, a source
//   memory pivot and enable/hflip controls. Object parameters live in a
//   shadow bank written via cfg_* and are copied into the active bank once
//   per frame at (vga_h == 0, vga_v == V_ACTIVE). The output is a 2-stage
//   pipelined source address; the lowest-indexed covering object wins.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   vga_h, vga_v  : VGA pixel/line counters
//   pix_valid     : counters describe an active-area pixel this cycle
//   cfg_we        : shadow register write strobe
//   cfg_idx       : object being written
//   cfg_field     : 0 pivot_h, 1 pivot_v, 2 mem_pivot_h, 3 mem_pivot_v,
//                   4 width, 5 height, 6 ctrl (bit0 obj_en, bit1 hflip)
//   cfg_data      : write data
//   addr          : source memory address (2 cycles after the pixel)
//   en            : some enabled object covers the pixel
//   obj_id        : winning object index
//   out_valid     : pix_valid delayed by 2 cycles
//   committed     : one-cycle pulse after shadow -> active copy
module obj_layer_addr #(
  parameter int unsigned NUM_OBJ     = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned MEM_STRIDE  = 320,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned V_ACTIVE    = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] vga_h,
  input  logic [COORD_W-1:0] vga_v,
  input  logic               pix_valid,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [2:0]         cfg_field,
  input  logic [COORD_W-1:0] cfg_data,
  output logic [ADDR_W-1:0]  addr,
  output logic               en,
  output logic [IDX_W-1:0]   obj_id,
  output logic               out_valid,
  output logic               committed
);

  typedef enum logic [2:0] {
    F_PIVOT_H     = 3'd0,
    F_PIVOT_V     = 3'd1,
    F_MEM_PIVOT_H = 3'd2,
    F_MEM_PIVOT_V = 3'd3,
    F_WIDTH       = 3'd4,
    F_HEIGHT      = 3'd5,
    F_CTRL        = 3'd6,
    F_RSVD        = 3'd7
  } cfg_field_e;

  typedef struct packed {
    logic [COORD_W-1:0] pivot_h;
    logic [COORD_W-1:0] pivot_v;
    logic [COORD_W-1:0] mem_pivot_h;
    logic [COORD_W-1:0] mem_pivot_v;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic               hflip;
    logic               obj_en;
  } obj_t;

  obj_t shadow [NUM_OBJ];
  obj_t active [NUM_OBJ];

  logic commit_pt;
  assign commit_pt = (vga_v == COORD_W'(V_ACTIVE)) && (vga_h == '0);

  // Shadow/active banks. Nonblocking semantics make a write on the commit
  // edge land in shadow only; active takes the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      committed <= 1'b0;
    end else begin
      committed <= commit_pt;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        if (commit_pt)
          active[i] <= shadow[i];
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          case (cfg_field_e'(cfg_field))
            F_PIVOT_H:     shadow[i].pivot_h     <= cfg_data;
            F_PIVOT_V:     shadow[i].pivot_v     <= cfg_data;
            F_MEM_PIVOT_H: shadow[i].mem_pivot_h <= cfg_data;
            F_MEM_PIVOT_V: shadow[i].mem_pivot_v <= cfg_data;
            F_WIDTH:       shadow[i].width       <= cfg_data;
            F_HEIGHT:      shadow[i].height      <= cfg_data;
            F_CTRL: begin
              shadow[i].obj_en <= cfg_data[0];
              shadow[i].hflip  <= cfg_data[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Stage 1: per-object hit test and object-relative offsets.
  logic [COORD_W-1:0] h_log, v_log;
  assign h_log = vga_h >> SCALE_SHIFT;
  assign v_log = vga_v >> SCALE_SHIFT;

  logic [NUM_OBJ-1:0] hit_c;
  logic [COORD_W-1:0] dh_raw [NUM_OBJ];
  logic [COORD_W-1:0] dh_c   [NUM_OBJ];
  logic [COORD_W-1:0] dv_c   [NUM_OBJ];

  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      dh_raw[i] = h_log - active[i].pivot_h;
      dv_c[i]   = v_log - active[i].pivot_v;
      // Explicit >= guards stop a wrapped difference from passing as in-range.
      hit_c[i]  = active[i].obj_en && pix_valid &&
                  (h_log >= active[i].pivot_h) && (dh_raw[i] < active[i].width) &&
                  (v_log >= active[i].pivot_v) && (dv_c[i] < active[i].height);
      dh_c[i]   = active[i].hflip ? (active[i].width - COORD_W'(1) - dh_raw[i])
                                  : dh_raw[i];
    end
  end

  logic [NUM_OBJ-1:0] s1_hit;
  logic [COORD_W-1:0] s1_dh [NUM_OBJ];
  logic [COORD_W-1:0] s1_dv [NUM_OBJ];
  logic               s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit   <= '0;
      s1_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        s1_dh[i] <= '0;
        s1_dv[i] <= '0;
      end
    end else begin
      s1_hit   <= hit_c;
      s1_valid <= pix_valid;
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        s1_dh[i] <= dh_c[i];
        s1_dv[i] <= dv_c[i];
      end
    end
  end

  // Stage 2: priority select (lowest index wins) and address formation.
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_addr  = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      if (!sel_found && s1_hit[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        // Evaluated modulo 2^ADDR_W: identical to the wide product truncated.
        sel_addr  = (ADDR_W'(active[i].mem_pivot_h) + ADDR_W'(s1_dh[i])) +
                    ADDR_W'(MEM_STRIDE) *
                    (ADDR_W'(active[i].mem_pivot_v) + ADDR_W'(s1_dv[i]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      en        <= 1'b0;
      obj_id    <= '0;
      out_valid <= 1'b0;
    end else begin
      addr      <= sel_addr;
      en        <= sel_found;
      obj_id    <= sel_idx;
      out_valid <= s1_valid;
    end
  end

endmodule

// File: tb/tb_obj_layer_addr.sv
module tb_obj_layer_addr;

  localparam int NOBJ = 4;
  localparam int STRIDE = 320;
  localparam int AMOD = 131072;
  localparam int VACT = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  vga_h, vga_v;
  logic        pix_valid;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [2:0]  cfg_field;
  logic [9:0]  cfg_data;
  logic [16:0] addr;
  logic        en;
  logic [1:0]  obj_id;
  logic        out_valid;
  logic        committed;

  int total = 0;
  int bad = 0;

  // Reference model: field arrays indexed [obj][field], field 6 = ctrl.
  int sh  [NOBJ][7];
  int act [NOBJ][7];

  typedef struct {
    bit v;
    bit e;
    int id;
    int a;
  } exp_t;

  always #5 clk = ~clk;

  obj_layer_addr #(
    .NUM_OBJ(4), .IDX_W(2), .COORD_W(10), .ADDR_W(17),
    .MEM_STRIDE(320), .SCALE_SHIFT(1), .V_ACTIVE(480)
  ) dut (
    .clk(clk), .rst(rst), .vga_h(vga_h), .vga_v(vga_v), .pix_valid(pix_valid),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .addr(addr), .en(en), .obj_id(obj_id), .out_valid(out_valid), .committed(committed)
  );

  function automatic exp_t model(int h, int v, bit pv);
    exp_t r;
    int lh, lv, ph, pvv, w, ht, dh;
    r.v = pv; r.e = 0; r.id = 0; r.a = 0;
    lh = h / 2;
    lv = v / 2;
    if (pv) begin
      for (int i = 0; i < NOBJ; i++) begin
        ph = act[i][0]; pvv = act[i][1]; w = act[i][4]; ht = act[i][5];
        if (!r.e && (act[i][6] % 2 == 1) &&
            lh >= ph && lh < ph + w && lv >= pvv && lv < pvv + ht) begin
          dh = lh - ph;
          if ((act[i][6] / 2) % 2 == 1) dh = w - 1 - dh;
          r.e = 1;
          r.id = i;
          r.a = ((act[i][2] + dh) + STRIDE * (act[i][3] + lv - pvv)) % AMOD;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NOBJ; i++)
      for (int f = 0; f < 7; f++) begin
        sh[i][f] = 0;
        act[i][f] = 0;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int fld, input int data);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_field = 3'(fld); cfg_data = 10'(data);
    tick();
    cfg_we = 0;
    if (fld < 7 && idx < NOBJ) sh[idx][fld] = data % 1024;
  endtask

  task automatic do_commit();
    vga_v = 10'(VACT); vga_h = 0; pix_valid = 0;
    tick();
    act = sh;
    vga_v = 0;
  endtask

  task automatic send_pix(input int h, input int v);
    vga_h = 10'(h); vga_v = 10'(v); pix_valid = 1;
    tick();
    pix_valid = 0;
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1; tick(); rst = 0;
    model_reset();
  endtask

  task automatic setup_obj0(input int ctrl);
    cfg_write(0, 0, 10); cfg_write(0, 1, 20); cfg_write(0, 2, 32);
    cfg_write(0, 3, 4);  cfg_write(0, 4, 16); cfg_write(0, 5, 8);
    cfg_write(0, 6, ctrl);
  endtask

  task automatic test_reset();
    vga_h = 30; vga_v = 44; pix_valid = 1; cfg_we = 0; cfg_idx = 0;
    cfg_field = 0; cfg_data = 0; rst = 1;
    tick(); tick();
    total++;
    if (addr !== 0 || en !== 0 || out_valid !== 0 || obj_id !== 0 || committed !== 0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%0d en=%b ov=%b id=%0d cm=%b, want all 0",
               addr, en, out_valid, obj_id, committed);
    end
    rst = 0; pix_valid = 0;
    model_reset();
    setup_obj0(1);
    send_pix(30, 44);
    total++;
    if (en !== 0 || out_valid !== 1) begin
      bad++;
      $display("FAIL precommit_en: got en=%b ov=%b, want en=0 ov=1", en, out_valid);
    end
  endtask

  task automatic test_single();
    do_commit();
    send_pix(30, 44);
    total++;
    if (en !== 1 || obj_id !== 0 || addr !== 1957 || out_valid !== 1) begin
      bad++;
      $display("FAIL single_hit: got en=%b id=%0d addr=%0d, want en=1 id=0 addr=1957", en, obj_id, addr);
    end
    send_pix(18, 44);
    total++;
    if (en !== 0 || addr !== 0 || obj_id !== 0) begin
      bad++;
      $display("FAIL single_left_miss: got en=%b addr=%0d, want en=0 addr=0", en, addr);
    end
    send_pix(30, 38);
    total++;
    if (en !== 0) begin
      bad++;
      $display("FAIL single_top_miss: got en=%b, want 0", en);
    end
  endtask

  task automatic test_hflip();
    int hs[4];
    int want_en[4];
    int want_a[4];
    hs = '{30, 20, 50, 52};
    want_en = '{1, 1, 1, 0};
    want_a = '{1962, 1967, 1952, 0};
    cfg_write(0, 6, 3);
    do_commit();
    for (int k = 0; k < 4; k++) begin
      send_pix(hs[k], 44);
      total++;
      if (en !== 1'(want_en[k]) || addr !== 17'(want_a[k])) begin
        bad++;
        $display("FAIL hflip_h%0d: got en=%b addr=%0d, want en=%0d addr=%0d",
                 hs[k], en, addr, want_en[k], want_a[k]);
      end
    end
  endtask

  task automatic test_priority();
    cfg_write(0, 4, 0);
    cfg_write(1, 0, 30); cfg_write(1, 1, 30); cfg_write(1, 2, 0);
    cfg_write(1, 3, 0);  cfg_write(1, 4, 20); cfg_write(1, 5, 20); cfg_write(1, 6, 1);
    cfg_write(3, 0, 35); cfg_write(3, 1, 35); cfg_write(3, 2, 100);
    cfg_write(3, 3, 50); cfg_write(3, 4, 10); cfg_write(3, 5, 10); cfg_write(3, 6, 1);
    do_commit();
    send_pix(80, 80);
    total++;
    if (en !== 1 || obj_id !== 1 || addr !== 3210) begin
      bad++;
      $display("FAIL prio_obj1: got en=%b id=%0d addr=%0d, want en=1 id=1 addr=3210", en, obj_id, addr);
    end
    send_pix(20, 40);
    total++;
    if (en !== 0) begin
      bad++;
      $display("FAIL prio_width0: got en=%b, want 0", en);
    end
    cfg_write(1, 6, 0);
    cfg_write(3, 7, 1023);
    do_commit();
    send_pix(80, 80);
    total++;
    if (en !== 1 || obj_id !== 3 || addr !== 17705) begin
      bad++;
      $display("FAIL prio_obj3: got en=%b id=%0d addr=%0d, want en=1 id=3 addr=17705", en, obj_id, addr);
    end
  endtask

  task automatic test_double_buffer();
    pulse_reset();
    setup_obj0(1);
    do_commit();
    cfg_write(0, 0, 12);
    send_pix(30, 44);
    total++;
    if (addr !== 1957 || en !== 1) begin
      bad++;
      $display("FAIL dbuf_old: got en=%b addr=%0d, want en=1 addr=1957", en, addr);
    end
    // write landing on the commit edge
    vga_v = 10'(VACT); vga_h = 0; pix_valid = 0;
    cfg_we = 1; cfg_idx = 0; cfg_field = 0; cfg_data = 14;
    tick();
    cfg_we = 0; vga_v = 0;
    act = sh;
    sh[0][0] = 14;
    total++;
    if (committed !== 1) begin
      bad++;
      $display("FAIL dbuf_pulse: got committed=%b, want 1", committed);
    end
    tick();
    total++;
    if (committed !== 0) begin
      bad++;
      $display("FAIL dbuf_pulse_end: got committed=%b, want 0", committed);
    end
    send_pix(30, 44);
    total++;
    if (addr !== 1955 || committed !== 0) begin
      bad++;
      $display("FAIL dbuf_mid: got addr=%0d cm=%b, want addr=1955 cm=0", addr, committed);
    end
    do_commit();
    send_pix(30, 44);
    total++;
    if (addr !== 1953) begin
      bad++;
      $display("FAIL dbuf_next: got addr=%0d, want 1953", addr);
    end
  endtask

  task automatic test_pipeline();
    exp_t q[$];
    exp_t e;
    bit pat[8];
    pat = '{1, 1, 0, 1, 1, 0, 1, 0};
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        vga_h = 10'(28 + 2 * k); vga_v = 44; pix_valid = pat[k];
        q.push_back(model(28 + 2 * k, 44, pat[k]));
      end else pix_valid = 0;
      tick();
      if (k >= 1) begin
        e = q.pop_front();
        total++;
        if (out_valid !== e.v || en !== e.e || obj_id !== 2'(e.id) || addr !== 17'(e.a)) begin
          bad++;
          $display("FAIL pipe_pix%0d: got ov=%b en=%b id=%0d addr=%0d, want ov=%b en=%b id=%0d addr=%0d",
                   k - 1, out_valid, en, obj_id, addr, e.v, e.e, e.id, e.a);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    vga_h = 30; vga_v = 44; pix_valid = 1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    total++;
    if (en !== 0 || out_valid !== 0 || addr !== 0) begin
      bad++;
      $display("FAIL midreset_flush: got en=%b ov=%b addr=%0d, want 0 0 0", en, out_valid, addr);
    end
    model_reset();
    pix_valid = 0;
    send_pix(30, 44);
    total++;
    if (en !== 0 || out_valid !== 1) begin
      bad++;
      $display("FAIL midreset_cleared: got en=%b ov=%b, want en=0 ov=1", en, out_valid);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int h, v, val;
    bit pv;
    pulse_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NOBJ; i++)
        for (int f = 0; f < 8; f++) begin
          case (f)
            0, 1: val = $urandom_range(0, 150);
            2, 3: val = $urandom_range(0, 1023);
            4, 5: val = $urandom_range(0, 60);
            6: val = $urandom_range(0, 3);
            default: val = $urandom_range(0, 1023);
          endcase
          cfg_write(i, f, val);
        end
      do_commit();
      for (int k = 0; k <= 150; k++) begin
        if (k < 150) begin
          h = $urandom_range(0, 399); v = $urandom_range(0, 399);
          pv = ($urandom_range(0, 3) != 0);
          vga_h = 10'(h); vga_v = 10'(v); pix_valid = pv;
          q.push_back(model(h, v, pv));
        end else pix_valid = 0;
        tick();
        if (k >= 1) begin
          e = q.pop_front();
          total++;
          if (out_valid !== e.v || en !== e.e || obj_id !== 2'(e.id) || addr !== 17'(e.a)) begin
            bad++;
            $display("FAIL rnd_r%0d_p%0d: got ov=%b en=%b id=%0d addr=%0d, want ov=%b en=%b id=%0d addr=%0d",
                     r, k - 1, out_valid, en, obj_id, addr, e.v, e.e, e.id, e.a);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hflip();
    test_priority();
    test_double_buffer();
    test_pipeline();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
